// File: rtl/k10_retire_buffer.sv
// Retire-record FIFO between WB and the trace consumer: normalizes rd fields, tags a retire sequence number, counts drops.
// Push-to-o_valid latency 1 cycle, no bypass; never stalls WB, drops when full without a pop; head holds while !i_ready.
module k10_retire_buffer #(
  parameter int DEPTH      = 8,
  parameter bit FILTER_GPR = 1'b0,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_valid,
  input  logic [31:0]   i_wb_pc,
  input  logic [31:0]   i_wb_instr,
  input  logic [4:0]    i_wb_rd_addr,
  input  logic [31:0]   i_wb_rd_data,
  input  logic          i_wb_rd_wr_en,
  input  logic [1:0]    i_wb_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_instr,
  output logic [4:0]    o_rd_addr,
  output logic [31:0]   o_rd_data,
  output logic          o_rd_wr_en,
  output logic [1:0]    o_mode,
  output logic [31:0]   o_seq,
  output logic [CW-1:0] o_count,
  output logic [15:0]   o_drop_cnt,
  output logic          o_overflow,
  input  logic          i_clr_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wr_en;
    logic [1:0]  mode;
    logic [31:0] seq;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          wr_rec;
  rec_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   seq_q;
  logic [15:0]   drop_cnt;
  logic          overflow;
  logic          wr_en_norm;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_acc;
  logic          drop;

  always_comb begin
    wr_en_norm = i_wb_rd_wr_en && (i_wb_rd_addr != 5'd0);
    push_req   = i_wb_valid && (!FILTER_GPR || wr_en_norm);
    full       = (count == CW'(DEPTH));
    pop        = (count != '0) && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_acc   = push_req && (!full || pop);
    drop       = push_req && full && !pop;

    wr_rec          = '0;
    wr_rec.pc       = i_wb_pc;
    wr_rec.instr    = i_wb_instr;
    wr_rec.rd_addr  = i_wb_rd_addr;
    wr_rec.rd_data  = wr_en_norm ? i_wb_rd_data : 32'd0;
    wr_rec.rd_wr_en = wr_en_norm;
    wr_rec.mode     = i_wb_mode;
    wr_rec.seq      = seq_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_acc) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq_q    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (i_wb_valid) begin
        seq_q <= seq_q + 32'd1;
      end
      if (i_clr_overflow) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign o_valid    = (count != '0);
  assign o_pc       = head.pc;
  assign o_instr    = head.instr;
  assign o_rd_addr  = head.rd_addr;
  assign o_rd_data  = head.rd_data;
  assign o_rd_wr_en = head.rd_wr_en;
  assign o_mode     = head.mode;
  assign o_seq      = head.seq;
  assign o_count    = count;
  assign o_drop_cnt = drop_cnt;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_k10_retire_buffer.sv
// Randomized + directed bench: two instances (no filter / GPR filter) against a queue-based reference model.
module tb_k10_retire_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [1:0]  mode;
    logic [31:0] seq;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [1:0]  wb_mode;
  logic        ready;
  logic        clr;
  bit          started = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic          o_valid;
    logic [31:0]   o_pc;
    logic [31:0]   o_instr;
    logic [4:0]    o_rd_addr;
    logic [31:0]   o_rd_data;
    logic          o_rd_wr_en;
    logic [1:0]    o_mode;
    logic [31:0]   o_seq;
    logic [CW-1:0] o_count;
    logic [15:0]   o_drop_cnt;
    logic          o_overflow;

    k10_retire_buffer #(.DEPTH(DEPTH), .FILTER_GPR(g == 1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_valid(wb_valid), .i_wb_pc(wb_pc), .i_wb_instr(wb_instr),
      .i_wb_rd_addr(wb_rd), .i_wb_rd_data(wb_data), .i_wb_rd_wr_en(wb_we),
      .i_wb_mode(wb_mode),
      .o_valid(o_valid), .i_ready(ready),
      .o_pc(o_pc), .o_instr(o_instr), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
      .o_rd_wr_en(o_rd_wr_en), .o_mode(o_mode), .o_seq(o_seq),
      .o_count(o_count), .o_drop_cnt(o_drop_cnt), .o_overflow(o_overflow),
      .i_clr_overflow(clr)
    );

    // Reference state: what the buffer holds, plus the records still owed to the consumer.
    rec_t        m_fifo[$];
    rec_t        sb[$];
    logic [31:0] m_seq  = '0;
    int          m_drop = 0;
    bit          m_ovf  = 1'b0;

    // Monitor: compare outputs against the model half a cycle after each edge.
    always @(negedge clk) begin
      rec_t act;
      #1;
      if (started) begin
        chk($sformatf("i%0d valid", g), 136'(o_valid), 136'(m_fifo.size() != 0));
        chk($sformatf("i%0d count", g), 136'(o_count), 136'(m_fifo.size()));
        chk($sformatf("i%0d drop_cnt", g), 136'(o_drop_cnt), 136'(m_drop));
        chk($sformatf("i%0d overflow", g), 136'(o_overflow), 136'(m_ovf));
        if (o_valid) begin
          act = '{pc: o_pc, instr: o_instr, rd: o_rd_addr, data: o_rd_data,
                  we: o_rd_wr_en, mode: o_mode, seq: o_seq};
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL i%0d head: got %h expected no record", g, act);
          end else begin
            chk($sformatf("i%0d head", g), 136'(act), 136'(sb[0]));
            if (ready) void'(sb.pop_front());
          end
        end
      end
    end

    // Model: apply the inputs that the coming edge will sample.
    always @(negedge clk) begin
      rec_t r;
      bit   we_n;
      bit   push;
      #2;
      if (!rst_n) begin
        m_fifo.delete();
        sb.delete();
        m_seq  = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
      end else begin
        we_n = wb_we && (wb_rd != 5'd0);
        push = wb_valid && ((g == 0) || we_n);
        if (m_fifo.size() != 0 && ready) void'(m_fifo.pop_front());
        if (push) begin
          if (m_fifo.size() < DEPTH) begin
            r = '{pc: wb_pc, instr: wb_instr, rd: wb_rd, data: (we_n ? wb_data : 32'd0),
                  we: we_n, mode: wb_mode, seq: m_seq};
            m_fifo.push_back(r);
            sb.push_back(r);
          end else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
        end
        if (clr) begin
          m_drop = 0;
          m_ovf  = 1'b0;
        end
        if (wb_valid) m_seq = m_seq + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    wb_pc    = '0;
    wb_instr = '0;
    wb_rd    = '0;
    wb_data  = '0;
    wb_we    = 1'b0;
    wb_mode  = '0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] data, input logic we, input logic [1:0] mode);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = instr;
    wb_rd    = rd;
    wb_data  = data;
    wb_we    = we;
    wb_mode  = mode;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    clr   = 1'b0;
    idle();
    tick();
    started = 1'b1;
    tick();
    chk("reset valid", 136'(g_inst[0].o_valid), 136'(0));
    chk("reset pc", 136'(g_inst[0].o_pc), 136'(0));
    chk("reset seq", 136'(g_inst[0].o_seq), 136'(0));
    chk("reset mode", 136'(g_inst[0].o_mode), 136'(0));
    rst_n = 1'b1;

    // Single M-mode retire.
    retire(32'h8000_0000, 32'h0010_0093, 5'd1, 32'd1, 1'b1, 2'd3);
    chk("single valid", 136'(g_inst[0].o_valid), 136'(1));
    chk("single seq", 136'(g_inst[0].o_seq), 136'(0));
    chk("single wr_en", 136'(g_inst[0].o_rd_wr_en), 136'(1));
    chk("single mode", 136'(g_inst[0].o_mode), 136'(3));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("single drained", 136'(g_inst[0].o_count), 136'(0));

    // rd=0 normalization, and filtering on the GPR-only instance.
    do_reset();
    retire(32'h8000_0010, 32'h0000_0013, 5'd0, 32'h1234, 1'b1, 2'd0);
    chk("x0 wr_en", 136'(g_inst[0].o_rd_wr_en), 136'(0));
    chk("x0 data", 136'(g_inst[0].o_rd_data), 136'(0));
    chk("filter count", 136'(g_inst[1].o_count), 136'(0));
    retire(32'h8000_0014, 32'h0050_0293, 5'd5, 32'h55, 1'b1, 2'd0);
    chk("filter next seq", 136'(g_inst[1].o_seq), 136'(1));
    ready = 1'b1;
    repeat (3) tick();

    // Overflow: 10 retires into an 8-deep stalled FIFO.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) retire($urandom, $urandom, 5'd7, $urandom, 1'b1, 2'd1);
    chk("ovf count", 136'(g_inst[0].o_count), 136'(8));
    chk("ovf drop_cnt", 136'(g_inst[0].o_drop_cnt), 136'(2));
    chk("ovf flag", 136'(g_inst[0].o_overflow), 136'(1));
    repeat (2) tick();
    chk("stall head", 136'(g_inst[0].o_seq), 136'(0));
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain seq", 136'(g_inst[0].o_seq), 136'(i));
      tick();
    end
    ready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) retire($urandom, $urandom, 5'd3, $urandom, 1'b1, 2'd0);
    ready = 1'b1;
    retire(32'hCAFE_0000, 32'h1, 5'd3, 32'h9, 1'b1, 2'd3);
    ready = 1'b0;
    chk("full pushpop count", 136'(g_inst[0].o_count), 136'(8));
    chk("full pushpop drop", 136'(g_inst[0].o_drop_cnt), 136'(0));
    ready = 1'b1;
    repeat (7) tick();
    chk("full pushpop last seq", 136'(g_inst[0].o_seq), 136'(8));
    tick();
    ready = 1'b0;

    // Clear colliding with a drop.
    do_reset();
    for (int i = 0; i < 9; i++) retire($urandom, $urandom, 5'd2, $urandom, 1'b1, 2'd0);
    chk("pre-clr drop", 136'(g_inst[0].o_drop_cnt), 136'(1));
    clr = 1'b1;
    retire(32'h1, 32'h2, 5'd2, 32'h3, 1'b1, 2'd0);
    clr = 1'b0;
    chk("clr drop_cnt", 136'(g_inst[0].o_drop_cnt), 136'(0));
    chk("clr overflow", 136'(g_inst[0].o_overflow), 136'(0));

    // Sequence wrap.
    do_reset();
    force g_inst[0].dut.seq_q = 32'hFFFF_FFFF;
    force g_inst[1].dut.seq_q = 32'hFFFF_FFFF;
    g_inst[0].m_seq = 32'hFFFF_FFFF;
    g_inst[1].m_seq = 32'hFFFF_FFFF;
    #1;
    release g_inst[0].dut.seq_q;
    release g_inst[1].dut.seq_q;
    retire(32'hA0, 32'hA1, 5'd4, 32'hA2, 1'b1, 2'd3);
    retire(32'hB0, 32'hB1, 5'd4, 32'hB2, 1'b1, 2'd3);
    chk("wrap seq hi", 136'(g_inst[0].o_seq), 136'(32'hFFFF_FFFF));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wrap seq lo", 136'(g_inst[0].o_seq), 136'(0));

    // Reset with records queued.
    for (int i = 0; i < 4; i++) retire($urandom, $urandom, 5'd9, $urandom, 1'b1, 2'd0);
    do_reset();
    chk("midreset valid", 136'(g_inst[0].o_valid), 136'(0));
    chk("midreset count", 136'(g_inst[0].o_count), 136'(0));

    // Randomized traffic, including x0 writes, clears and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      ready    = ($urandom_range(0, 99) < 45);
      clr      = ($urandom_range(0, 99) < 3);
      wb_valid = ($urandom_range(0, 99) < 65);
      wb_pc    = $urandom;
      wb_instr = $urandom;
      wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_data  = $urandom;
      wb_we    = 1'($urandom);
      wb_mode  = 2'($urandom);
      tick();
    end
    rst_n = 1'b1;
    clr   = 1'b0;
    ready = 1'b1;
    idle();
    repeat (DEPTH + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/k10_retire_buffer.md
Name: k10_retire_buffer

Overview:
Buffers per-instruction commit records captured from the K10 WB stage and presents them to a retirement consumer over a valid/ready handshake. The consumer is the simulation tracer or a debug trace port. Absorbs consumer back-pressure so that WB never stalls, and tags each record with a retire sequence number. Counts any records it has to drop. Synthesizable; sits between the WB stage and the trace consumer.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
FILTER_GPR, 0, 1 = enqueue only records that write a non-zero rd; 0 = enqueue every retired instruction
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_wb_valid  in  1  instruction retired this cycle
i_wb_pc  in  32  committed PC
i_wb_instr  in  32  instruction encoding
i_wb_rd_addr  in  5  destination register
i_wb_rd_data  in  32  writeback data
i_wb_rd_wr_en  in  1  register file write enable
i_wb_mode  in  priv_lvl_e  privilege level at retire
o_valid  out  1  head record available
i_ready  in  1  consumer accepts head
o_pc  out  32  head PC
o_instr  out  32  head encoding
o_rd_addr  out  5  head rd
o_rd_data  out  32  head rd data
o_rd_wr_en  out  1  head GPR-write flag (normalized)
o_mode  out  priv_lvl_e  head privilege
o_seq  out  32  head retire sequence number
o_count  out  CW  occupancy
o_drop_cnt  out  16  dropped-record count, saturating
o_overflow  out  1  sticky drop flag
i_clr_overflow  in  1  clears o_overflow and o_drop_cnt

Behaviour:
- Reset (i_rst_n=0 at posedge): FIFO empty, pointers=0, seq counter=0, o_drop_cnt=0, o_overflow=0. Data outputs are driven from the head entry; entries reset to 0, so every output reads 0 in reset. o_mode reads PRIV_U encoding 0. Reset mid-stream discards all entries with no partial pops.
- Seq counter: increments by 1 on every i_wb_valid, including filtered records. It wraps 0xFFFFFFFF -> 0. A record stores the counter value before the increment, so the first retire after reset has seq=0.
- Normalization at enqueue: the stored wr_en is i_wb_rd_wr_en && (i_wb_rd_addr != 0). If the stored wr_en is 0, the stored rd_data is 0. rd_addr and all other fields are stored as presented.
- push_req = i_wb_valid && (!FILTER_GPR || normalized wr_en).
- pop = o_valid && i_ready.
- o_valid = (o_count != 0). Head fields are first-word-fall-through.
- Latency: a record pushed at edge N is visible at o_valid after N (1 cycle). There is no combinational bypass, so when the FIFO is empty, a push and i_ready in the same cycle produce no pop.
- While o_valid && !i_ready, all head outputs hold stable.
- Full handling:
  - push_req && full && pop: the push is accepted and o_count is unchanged.
  - push_req && full && !pop: the record is dropped, o_drop_cnt += 1 (saturating at 0xFFFF), and o_overflow is set.
  - The seq counter still advances on a drop, so the consumer sees a gap in sequence numbers.
- i_clr_overflow: clears o_drop_cnt and o_overflow at the next edge. If a drop occurs in the same cycle, the clear has priority and both read 0 afterwards.
- Pointers wrap modulo DEPTH. o_count ranges 0..DEPTH.
- WB is never back-pressured; there is no ready output toward WB.

Test Plan:
- Reset, then a single retire with pc=0x80000000, instr=0x00100093, rd=1, data=1, M-mode. Required: o_valid=1 at the next cycle, o_seq=0, o_rd_wr_en=1, o_mode=PRIV_M. Pop; o_count returns to 0.
- Retire with rd=0 and wr_en=1, data=0x1234, FILTER_GPR=0. Required: o_rd_wr_en=0 and o_rd_data=0. Repeat with FILTER_GPR=1. Required: no record enqueued, and the next valid retire carries seq=1.
- i_ready=0 with 10 back-to-back retires, DEPTH=8. Required: o_count=8, o_drop_cnt=2, o_overflow=1. Drain 8 records; the seq values read 0..7 and the head holds stable while stalled.
- Full FIFO with a simultaneous push and pop. Required: o_count stays 8, no drop, and the new record appears last with the correct seq.
- i_clr_overflow asserted in the same cycle as a drop. Required: o_drop_cnt=0 and o_overflow=0 afterwards.
- Preload the seq counter near wrap (drive 2^32-1 retires or use a force in sim). Required: records with seq=0xFFFFFFFF then 0x00000000. Assert reset with 5 records queued. Required: o_valid=0 and o_count=0 the next cycle.
